// File: rtl/controller_snes_device.sv
// Device (pad) side of the SNES / GAMETANK serial controller protocol.
// The host drives latch (joy_strb) and data clock (joy_clk); this block
// latches a 12-bit button vector plus an ID nibble and shifts out 16
// active-low bits, bit0 (B) first, advancing on each host clock rise.

// Two-flop synchronizer followed by a stability filter: the filtered
// level only follows the synchronized input after FILTER consecutive
// samples disagree with it, so pulses shorter than FILTER cycles vanish.
module controller_snes_device_filter #(
   parameter int   FILTER  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic resetn,
   input  logic pin,
   output logic level
);

   localparam int CW = (FILTER > 1) ? $clog2(FILTER) : 1;

   logic [1:0]    sync;
   logic [CW-1:0] cnt;

   // Bring the asynchronous pin into the clk domain.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync <= {2{RST_VAL}};
      end else begin
         sync <= {sync[0], pin};
      end
   end

   // Count disagreeing samples; commit the new level after FILTER of them.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         level <= RST_VAL;
         cnt   <= '0;
      end else if (sync[1] == level) begin
         cnt <= '0;
      end else if (cnt == CW'(FILTER - 1)) begin
         level <= sync[1];
         cnt   <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

module controller_snes_device #(
   parameter int       FILTER = 2,
   parameter logic [3:0] ID   = 4'b0000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        joy_strb,
   input  logic        joy_clk,
   output logic        joy_data,
   input  logic [11:0] buttons,
   output logic        poll_done,
   output logic        shifting
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LATCH = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t      state, state_nxt;
   logic [15:0] shreg, shreg_nxt;
   logic [4:0]  bit_cnt, bit_cnt_nxt;
   logic        joy_data_nxt;
   logic        poll_done_nxt;
   logic        shifting_nxt;

   logic        strb_f, strb_q;
   logic        clk_f, clk_q;
   logic        strb_rise;
   logic        clk_rise;
   logic [15:0] load_val;

   controller_snes_device_filter #(
      .FILTER  (FILTER),
      .RST_VAL (1'b0)
   ) u_strb_filter (
      .clk    (clk),
      .resetn (resetn),
      .pin    (joy_strb),
      .level  (strb_f)
   );

   // The host clock idles high, so its filter comes out of reset high.
   controller_snes_device_filter #(
      .FILTER  (FILTER),
      .RST_VAL (1'b1)
   ) u_clk_filter (
      .clk    (clk),
      .resetn (resetn),
      .pin    (joy_clk),
      .level  (clk_f)
   );

   // Delayed copies of the filtered levels for edge detection.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         strb_q <= 1'b0;
         clk_q  <= 1'b1;
      end else begin
         strb_q <= strb_f;
         clk_q  <= clk_f;
      end
   end

   assign strb_rise = strb_f & ~strb_q;
   assign clk_rise  = clk_f & ~clk_q;

   // Wire format is active-low; the ID nibble rides in bits 13-16.
   assign load_val = {~ID, ~buttons};

   // State and datapath registers; reset puts the pins in the idle pattern.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         shreg     <= '1;
         bit_cnt   <= '0;
         joy_data  <= 1'b1;
         poll_done <= 1'b0;
         shifting  <= 1'b0;
      end else begin
         state     <= state_nxt;
         shreg     <= shreg_nxt;
         bit_cnt   <= bit_cnt_nxt;
         joy_data  <= joy_data_nxt;
         poll_done <= poll_done_nxt;
         shifting  <= shifting_nxt;
      end
   end

   // Next-state and register updates; a strobe rise overrides everything,
   // including a clock edge landing in the same cycle.
   always_comb begin
      state_nxt     = state;
      shreg_nxt     = shreg;
      bit_cnt_nxt   = bit_cnt;
      joy_data_nxt  = joy_data;
      poll_done_nxt = 1'b0;
      shifting_nxt  = shifting;

      if (strb_rise) begin
         state_nxt    = LATCH;
         shreg_nxt    = load_val;
         bit_cnt_nxt  = '0;
         joy_data_nxt = load_val[0];
         shifting_nxt = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               joy_data_nxt = 1'b1;
               if (strb_f) begin
                  state_nxt    = LATCH;
                  shreg_nxt    = load_val;
                  bit_cnt_nxt  = '0;
                  joy_data_nxt = load_val[0];
               end
            end
            LATCH: begin
               if (strb_f) begin
                  // Transparent while the strobe is held.
                  shreg_nxt    = load_val;
                  bit_cnt_nxt  = '0;
                  joy_data_nxt = load_val[0];
               end else begin
                  // Strobe released: keep the last captured vector.
                  state_nxt    = SHIFT;
                  shifting_nxt = 1'b1;
               end
            end
            SHIFT: begin
               if (clk_rise) begin
                  shreg_nxt    = {1'b0, shreg[15:1]};
                  joy_data_nxt = shreg[1];
                  bit_cnt_nxt  = bit_cnt + 5'd1;
                  if (bit_cnt == 5'd15) begin
                     state_nxt     = DONE;
                     shifting_nxt  = 1'b0;
                     poll_done_nxt = 1'b1;
                     joy_data_nxt  = 1'b0;
                  end
               end
            end
            DONE: begin
               // Reads past bit 16 see a constant 0 (pad present).
               joy_data_nxt = 1'b0;
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_controller_snes_device.sv
// Directed bench for controller_snes_device: one standard pad (ID=0) and
// one GAMETANK pad (ID=4'b1010) share the host pins and are checked together.
`timescale 1ns/1ps
module tb_controller_snes_device;

   logic        clk;
   logic        resetn;
   logic        joy_strb;
   logic        joy_clk;
   logic [11:0] buttons;
   logic        joy_data0, poll_done0, shifting0;
   logic        joy_data1, poll_done1, shifting1;

   int errors = 0;
   int checks = 0;
   int pc0 = 0;
   int pc1 = 0;

   controller_snes_device #(.FILTER(2), .ID(4'b0000)) dut0 (
      .clk       (clk),
      .resetn    (resetn),
      .joy_strb  (joy_strb),
      .joy_clk   (joy_clk),
      .joy_data  (joy_data0),
      .buttons   (buttons),
      .poll_done (poll_done0),
      .shifting  (shifting0)
   );

   controller_snes_device #(.FILTER(2), .ID(4'b1010)) dut1 (
      .clk       (clk),
      .resetn    (resetn),
      .joy_strb  (joy_strb),
      .joy_clk   (joy_clk),
      .joy_data  (joy_data1),
      .buttons   (buttons),
      .poll_done (poll_done1),
      .shifting  (shifting1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count poll_done high cycles; a one-cycle pulse adds exactly 1.
   always @(negedge clk) begin
      if (poll_done0) pc0 <= pc0 + 1;
      if (poll_done1) pc1 <= pc1 + 1;
   end

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic strobe(input int len);
      joy_strb = 1'b1;
      cyc(len);
      joy_strb = 1'b0;
      cyc(10);
   endtask

   // Host reads n bits: sample at each clock fall, then raise the clock.
   task automatic read_bits(input int n, output logic [15:0] v0, output logic [15:0] v1);
      v0 = '0;
      v1 = '0;
      for (int i = 0; i < n; i++) begin
         v0[i] = joy_data0;
         v1[i] = joy_data1;
         joy_clk = 1'b0;
         cyc(10);
         joy_clk = 1'b1;
         cyc(10);
      end
   endtask

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic test_reset;
      resetn   = 1'b0;
      joy_strb = 1'b0;
      joy_clk  = 1'b1;
      buttons  = 12'h000;
      cyc(3);
      chk("reset_data0", {15'd0, joy_data0}, 16'd1);
      chk("reset_data1", {15'd0, joy_data1}, 16'd1);
      chk("reset_poll", {14'd0, poll_done0, poll_done1}, 16'd0);
      chk("reset_shift", {14'd0, shifting0, shifting1}, 16'd0);
      resetn = 1'b1;
      cyc(10);
      chk("idle_data", {14'd0, joy_data0, joy_data1}, 16'd3);
      chk("idle_shift", {14'd0, shifting0, shifting1}, 16'd0);
   endtask

   task automatic test_standard;
      logic [15:0] v0, v1;
      int b0, b1;
      b0 = pc0; b1 = pc1;
      buttons = 12'h001;
      strobe(12);
      chk("std_shifting", {14'd0, shifting0, shifting1}, 16'd3);
      read_bits(16, v0, v1);
      cyc(5);
      chk("std_stream0", v0, 16'hFFFE);
      chk("std_stream1", v1, 16'h5FFE);
      chk("std_poll0", 16'(pc0 - b0), 16'd1);
      chk("std_poll1", 16'(pc1 - b1), 16'd1);
      chk("std_after_data", {14'd0, joy_data0, joy_data1}, 16'd0);
      chk("std_after_shift", {14'd0, shifting0, shifting1}, 16'd0);
      // Extra clock past bit 16 still reads 0 and raises no poll_done.
      read_bits(1, v0, v1);
      chk("std_extra", {14'd0, v0[0], v1[0]}, 16'd0);
      chk("std_extra_poll", 16'(pc0 - b0), 16'd1);
   endtask

   task automatic test_all_pressed;
      logic [15:0] v0, v1;
      int b1;
      b1 = pc1;
      buttons = 12'hFFF;
      strobe(12);
      read_bits(16, v0, v1);
      cyc(5);
      chk("all_stream0", v0, 16'hF000);
      chk("all_stream1", v1, 16'h5000);
      chk("all_poll1", 16'(pc1 - b1), 16'd1);
   endtask

   task automatic test_transparency;
      logic [15:0] v0, v1;
      buttons  = 12'h000;
      joy_strb = 1'b1;
      cyc(10);
      buttons  = 12'h800;
      cyc(10);
      joy_strb = 1'b0;
      cyc(10);
      buttons  = 12'hFFF;
      read_bits(16, v0, v1);
      cyc(5);
      chk("transp_stream0", v0, 16'hF7FF);
      chk("transp_stream1", v1, 16'h57FF);
   endtask

   task automatic test_abort;
      logic [15:0] v0, v1;
      int b0;
      b0 = pc0;
      buttons = 12'h001;
      strobe(12);
      read_bits(7, v0, v1);
      chk("abort_first7", {9'd0, v0[6:0]}, 16'h007E);
      joy_strb = 1'b1;
      cyc(10);
      chk("abort_shift", {14'd0, shifting0, shifting1}, 16'd0);
      chk("abort_data", {14'd0, joy_data0, joy_data1}, 16'd0);
      chk("abort_nopoll", 16'(pc0 - b0), 16'd0);
      joy_strb = 1'b0;
      cyc(10);
      read_bits(16, v0, v1);
      cyc(5);
      chk("abort_stream0", v0, 16'hFFFE);
      chk("abort_poll", 16'(pc0 - b0), 16'd1);
   endtask

   task automatic test_glitch;
      logic [15:0] a0, a1, r0, r1;
      int b0;
      b0 = pc0;
      buttons = 12'h011;  // wire 16'hFFEE: bit3 = 1, bit0 and bit4 = 0
      strobe(12);
      read_bits(3, a0, a1);
      chk("glitch_pre", {15'd0, joy_data0}, 16'd1);
      joy_strb = 1'b1;
      cyc(1);
      joy_strb = 1'b0;
      cyc(10);
      chk("glitch_strb_data", {15'd0, joy_data0}, 16'd1);
      chk("glitch_strb_shift", {14'd0, shifting0, shifting1}, 16'd3);
      joy_clk = 1'b0;
      cyc(1);
      joy_clk = 1'b1;
      cyc(10);
      chk("glitch_clk_data", {15'd0, joy_data0}, 16'd1);
      read_bits(13, r0, r1);
      cyc(5);
      chk("glitch_stream0", (r0 << 3) | {13'd0, a0[2:0]}, 16'hFFEE);
      chk("glitch_poll", 16'(pc0 - b0), 16'd1);
   endtask

   task automatic test_reset_mid;
      logic [15:0] v0, v1;
      int b0;
      buttons = 12'h001;
      strobe(12);
      read_bits(5, v0, v1);
      b0 = pc0;
      resetn = 1'b0;
      #2;
      chk("rstmid_data", {14'd0, joy_data0, joy_data1}, 16'd3);
      chk("rstmid_shift", {14'd0, shifting0, shifting1}, 16'd0);
      cyc(3);
      resetn = 1'b1;
      cyc(5);
      read_bits(3, v0, v1);
      chk("rstmid_ign_data", {14'd0, joy_data0, joy_data1}, 16'd3);
      chk("rstmid_ign_shift", {14'd0, shifting0, shifting1}, 16'd0);
      chk("rstmid_ign_poll", 16'(pc0 - b0), 16'd0);
      strobe(12);
      read_bits(16, v0, v1);
      cyc(5);
      chk("rstmid_stream0", v0, 16'hFFFE);
      chk("rstmid_poll", 16'(pc0 - b0), 16'd1);
   endtask

   initial begin
      test_reset;
      test_standard;
      test_all_pressed;
      test_transparency;
      test_abort;
      test_glitch;
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
